// File: rtl/sensor_err_monitor.sv
// sensor_err_monitor: synchronizes and debounces the sensor error, raising a sticky alarm
// with a sensor snapshot, an entry strobe and a saturating event count.
module sensor_err_monitor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 error_in,
    input  logic [3:0]           sensors,
    input  logic                 clear,
    output logic                 alarm,
    output logic                 err_pulse,
    output logic [3:0]           snapshot,
    output logic [CNT_WIDTH-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, QUALIFY, ALARM} state_t;

    localparam logic [3:0]           QMAX    = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [3:0]           qcnt_q, qcnt_d;
    logic                 err_meta_q, err_sync_q;
    logic [3:0]           sens_meta_q, sens_sync_q;
    logic                 alarm_q, alarm_d;
    logic                 pulse_q, pulse_d;
    logic [3:0]           snapshot_q, snapshot_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 enter;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        enter   = 1'b0;
        case (state_q)
            IDLE: if (err_sync_q) begin
                state_d = QUALIFY;
                qcnt_d  = 4'd1;
            end
            QUALIFY: if (!err_sync_q) begin
                state_d = IDLE;
                qcnt_d  = 4'd0;
            end else if (qcnt_q == QMAX) begin
                state_d = ALARM;
                enter   = 1'b1;
            end else begin
                qcnt_d = qcnt_q + 4'd1;
            end
            ALARM: if (clear && !err_sync_q) begin
                state_d = IDLE;
                qcnt_d  = 4'd0;
            end
            default: begin
                state_d = IDLE;
                qcnt_d  = 4'd0;
            end
        endcase
        // Only the entry edge updates the capture and the counter, so one episode counts once.
        snapshot_d = enter ? sens_sync_q : snapshot_q;
        count_d    = (enter && count_q != CNT_MAX) ? count_q + 1'b1 : count_q;
        pulse_d    = enter;
        alarm_d    = (state_d == ALARM);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_meta_q  <= 1'b0;
            err_sync_q  <= 1'b0;
            sens_meta_q <= 4'b0;
            sens_sync_q <= 4'b0;
            state_q     <= IDLE;
            qcnt_q      <= 4'd0;
            alarm_q     <= 1'b0;
            pulse_q     <= 1'b0;
            snapshot_q  <= 4'b0;
            count_q     <= '0;
        end else begin
            err_meta_q  <= error_in;
            err_sync_q  <= err_meta_q;
            sens_meta_q <= sensors;
            sens_sync_q <= sens_meta_q;
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            alarm_q     <= alarm_d;
            pulse_q     <= pulse_d;
            snapshot_q  <= snapshot_d;
            count_q     <= count_d;
        end
    end

    assign alarm     = alarm_q;
    assign err_pulse = pulse_q;
    assign snapshot  = snapshot_q;
    assign err_count = count_q;
endmodule

// File: tb/tb_sensor_err_monitor.sv
// tb_sensor_err_monitor: directed and randomized checks of sensor_err_monitor against a
// run-length reference model; a second instance with a 2-bit counter covers saturation.
module tb_sensor_err_monitor;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       error_in = 1'b0;
    logic [3:0] sensors = 4'b0;
    logic       clear = 1'b0;
    logic       alarm, err_pulse, alarm2, pulse2;
    logic [3:0] snapshot, snapshot2;
    logic [7:0] err_count;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sync pipeline as 2-deep delay, debounce as a run length of high samples.
    int   m_run;
    bit   m_alarm, m_pulse;
    bit   m_e1, m_e2;
    logic [3:0] m_v1, m_v2, m_snap;
    int   m_cnt, m_cnt2;

    logic [15:0] obs, expv;

    always #5 clk = ~clk;

    sensor_err_monitor #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .n_rst(n_rst), .error_in(error_in), .sensors(sensors), .clear(clear),
        .alarm(alarm), .err_pulse(err_pulse), .snapshot(snapshot), .err_count(err_count)
    );

    sensor_err_monitor #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .n_rst(n_rst), .error_in(error_in), .sensors(sensors), .clear(clear),
        .alarm(alarm2), .err_pulse(pulse2), .snapshot(snapshot2), .err_count(cnt2)
    );

    assign obs  = {alarm, err_pulse, snapshot, err_count, cnt2};
    assign expv = {m_alarm, m_pulse, m_snap, 8'(m_cnt), 2'(m_cnt2)};

    task automatic model_reset();
        m_run = 0; m_alarm = 0; m_pulse = 0; m_e1 = 0; m_e2 = 0;
        m_v1 = 0; m_v2 = 0; m_snap = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_step();
        m_pulse = 0;
        if (m_alarm) begin
            if (clear && !m_e2) begin
                m_alarm = 0;
                m_run = 0;
            end
        end else begin
            m_run = m_e2 ? m_run + 1 : 0;
            if (m_run == D) begin
                m_alarm = 1;
                m_pulse = 1;
                m_snap = m_v2;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
        m_e2 = m_e1; m_e1 = error_in;
        m_v2 = m_v1; m_v1 = sensors;
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        model_reset();
        tick(); tick();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        error_in = 1'b1; sensors = 4'b1111; clear = 1'b0;
        n_rst = 1'b0;
        model_reset();
        tick(); tick(); tick();
        n_cmp++;
        if (obs !== 16'h0) begin
            n_err++; $display("FAIL reset_outputs got %h exp 0000", obs);
        end
        n_rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (alarm !== (i == 6) || obs !== expv) begin
                n_err++; $display("FAIL reset_release edge %0d got %h exp %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_qualify();
        error_in = 1'b0; sensors = 4'b1010;
        do_reset();
        error_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_cmp++;
            if (alarm !== (i >= 6) || err_pulse !== (i == 6) || obs !== expv) begin
                n_err++; $display("FAIL qualify edge %0d got %h exp %h", i, obs, expv);
            end
        end
        n_cmp++;
        if (snapshot !== 4'b1010 || err_count !== 8'd1) begin
            n_err++; $display("FAIL qualify_capture snap %b cnt %0d exp 1010 1", snapshot, err_count);
        end
    endtask

    task automatic test_glitch();
        error_in = 1'b0;
        do_reset();
        error_in = 1'b1;
        tick(); tick(); tick();
        error_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (alarm !== 1'b0 || err_count !== 8'd0 || obs !== expv) begin
                n_err++; $display("FAIL glitch cycle %0d got %h exp %h", i, obs, expv);
            end
        end
        error_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (alarm !== (i == 6) || obs !== expv) begin
                n_err++; $display("FAIL glitch_requalify edge %0d got %h exp %h", i, obs, expv);
            end
        end
        error_in = 1'b0;
    endtask

    task automatic test_clear();
        error_in = 1'b0; sensors = 4'b0110;
        do_reset();
        error_in = 1'b1;
        repeat (6) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        n_cmp++;
        if (alarm !== 1'b1 || obs !== expv) begin
            n_err++; $display("FAIL clear_ignored got %h exp %h", obs, expv);
        end
        error_in = 1'b0;
        tick(); tick();
        n_cmp++;
        if (alarm !== 1'b1) begin
            n_err++; $display("FAIL clear_hold alarm %b exp 1", alarm);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_cmp++;
        if (alarm !== 1'b0 || obs !== expv) begin
            n_err++; $display("FAIL clear_release got %h exp %h", obs, expv);
        end
        error_in = 1'b1; sensors = 4'b0011;
        repeat (6) tick();
        n_cmp++;
        if (alarm !== 1'b1 || err_pulse !== 1'b1 || err_count !== 8'd2 || snapshot !== 4'b0011) begin
            n_err++; $display("FAIL clear_requalify got %h exp a1 p1 snap 0011 cnt 2", obs);
        end
        // clear held throughout: entry still happens, exit waits for the error to go away
        clear = 1'b1; error_in = 1'b0;
        tick(); tick(); tick();
        error_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (obs !== expv) begin
                n_err++; $display("FAIL clear_held cycle %0d got %h exp %h", i, obs, expv);
            end
        end
        n_cmp++;
        if (err_count !== 8'd3 || alarm !== 1'b1) begin
            n_err++; $display("FAIL clear_held_entry cnt %0d alarm %b exp 3 1", err_count, alarm);
        end
        clear = 1'b0; error_in = 1'b0;
    endtask

    task automatic test_saturation();
        int pulses;
        int want;
        bit seen;
        error_in = 1'b0; clear = 1'b0;
        do_reset();
        pulses = 0;
        for (int ep = 1; ep <= 5; ep++) begin
            error_in = 1'b1; sensors = 4'(ep);
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (pulse2) pulses++;
                seen = alarm2;
            end
            want = (ep < 3) ? ep : 3;
            n_cmp++;
            if (!seen || cnt2 !== 2'(want) || obs !== expv) begin
                n_err++; $display("FAIL sat_episode %0d seen %b cnt %0d exp %0d obs %h model %h", ep, seen, cnt2, want, obs, expv);
            end
            error_in = 1'b0; clear = 1'b1;
            for (int c = 0; c < 20 && alarm2; c++) tick();
            clear = 1'b0;
            n_cmp++;
            if (alarm2 !== 1'b0) begin
                n_err++; $display("FAIL sat_release %0d alarm %b exp 0", ep, alarm2);
            end
        end
        n_cmp++;
        if (pulses != 5 || err_count !== 8'd5) begin
            n_err++; $display("FAIL sat_pulses got %0d cnt8 %0d exp 5 5", pulses, err_count);
        end
    endtask

    task automatic test_async_reset();
        error_in = 1'b0; clear = 1'b0;
        do_reset();
        error_in = 1'b1; sensors = 4'b1100;
        repeat (4) tick();
        #2 n_rst = 1'b0; model_reset();
        #1;
        n_cmp++;
        if (obs !== 16'h0) begin
            n_err++; $display("FAIL async_qualify got %h exp 0000", obs);
        end
        @(negedge clk) n_rst = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_cmp++;
            if (alarm !== (i >= 6) || obs !== expv) begin
                n_err++; $display("FAIL async_recover edge %0d got %h exp %h", i, obs, expv);
            end
        end
        #2 n_rst = 1'b0; model_reset();
        #1;
        n_cmp++;
        if (obs !== 16'h0) begin
            n_err++; $display("FAIL async_alarm got %h exp 0000", obs);
        end
        @(negedge clk) n_rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (alarm !== (i == 6) || obs !== expv) begin
                n_err++; $display("FAIL async_recover2 edge %0d got %h exp %h", i, obs, expv);
            end
        end
        error_in = 1'b0;
    endtask

    task automatic test_random();
        int runleft;
        error_in = 1'b0; clear = 1'b0;
        do_reset();
        runleft = 0;
        for (int i = 0; i < 600; i++) begin
            if (runleft == 0) begin
                error_in = ~error_in;
                runleft = $urandom_range(1, 8);
            end
            runleft--;
            sensors = 4'($urandom);
            clear = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (obs !== expv) begin
                n_err++; $display("FAIL random cycle %0d got %h exp %h", i, obs, expv);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_qualify();
        test_glitch();
        test_clear();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sensor_err_monitor.md
Name: sensor_err_monitor

Overview:
Downstream consumer of the combinational sensor error detector's error output and its 4-bit sensors vector. Synchronizes both into the clock domain and debounces error, requiring DEBOUNCE_CYCLES consecutive high samples. On a qualified error it raises a sticky alarm, captures a snapshot of the sensors, pulses an event strobe and bumps a saturating event counter. The alarm stays up until software clears it and the error has gone away.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized high samples of error required to qualify; legal range 2..15.
CNT_WIDTH, 8, width of the event counter err_count.

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
error_in  input  1  raw error from the sensor error detector, asynchronous to clk
sensors  input  4  raw sensor vector feeding the detector, asynchronous to clk
clear  input  1  synchronous alarm acknowledge, level-sensitive
alarm  output  1  sticky qualified-error flag, registered
err_pulse  output  1  one-cycle strobe on entry to ALARM, registered
snapshot  output  4  synchronized sensors value captured on entry to ALARM
err_count  output  CNT_WIDTH  number of qualified error events, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: all flops cleared while n_rst=0.
  - state=IDLE, qcnt=0.
  - alarm=0, err_pulse=0, snapshot=4'b0000, err_count=0.
  - Synchronizer flops = 0.
  - Reset mid-operation (any state) returns to exactly these values immediately.
- Synchronizer: error_in and sensors each pass through 2 flops. err_sync and sens_sync are the second-stage outputs. The FSM uses only the synchronized values.
- qcnt: 4-bit qualify counter.
- FSM states and transitions:
  - IDLE:
    - err_sync=1 -> QUALIFY, qcnt<=1.
    - else stay.
  - QUALIFY:
    - err_sync=0 -> IDLE, qcnt<=0. A glitch shorter than DEBOUNCE_CYCLES samples never alarms.
    - err_sync=1 and qcnt==DEBOUNCE_CYCLES-1 -> ALARM.
    - else qcnt<=qcnt+1.
  - ALARM:
    - clear=1 and err_sync=0 -> IDLE, qcnt<=0.
    - else stay. clear is ignored while err_sync=1.
- Actions on the IDLE/QUALIFY->ALARM transition edge:
  - snapshot<=sens_sync.
  - err_pulse<=1 for exactly one cycle.
  - err_count<=err_count+1, holds at 2^CNT_WIDTH-1 once reached (no wrap).
- Outputs:
  - alarm = registered (state==ALARM).
  - snapshot and err_count hold their values outside the entry edge.
  - One alarm episode counts once, no matter how long error stays high.
- Latency: if error_in rises before clock edge 1 and stays high, alarm and err_pulse are first high after edge DEBOUNCE_CYCLES+2 (edge 6 for the default).
  - Alarm release: alarm falls on the first edge where clear=1 and err_sync=0.
- Simultaneous events:
  - clear asserted in IDLE or QUALIFY has no effect.
  - clear held continuously: ALARM is still entered, with pulse/count/snapshot. Exit happens only once err_sync=0.
  - error re-qualifying right after release starts a fresh episode from IDLE. It counts again.

Test Plan:
- Reset: hold n_rst=0 with error_in=1 and sensors=4'b1111 -> all outputs 0. Release reset: no alarm before edge 6.
- Qualify: sensors=4'b1010, error_in=1 held -> alarm=1 and err_pulse=1 after edge 6. err_pulse=0 after edge 7. snapshot=4'b1010, err_count=1.
- Glitch reject: error_in high for 3 synchronized samples then low -> alarm stays 0, err_count stays 0, FSM returns to IDLE.
- Clear rules:
  - In ALARM with error still high, pulse clear=1 -> alarm stays 1.
  - Drop error_in, wait 2 cycles, pulse clear -> alarm=0 next edge.
  - Requalify -> err_count=2.
- Saturation: CNT_WIDTH=2, run 5 qualify/clear episodes -> err_count reads 1,2,3,3,3. err_pulse fires all 5 times.
- Async reset mid-QUALIFY and mid-ALARM: assert n_rst=0 between clock edges -> outputs 0 without waiting for clk. Recovery behaves exactly as after the initial reset.
